dmem_arbiter: RTL and testbench

//  Shares the single-port data memory of the single-cycle RISC-V core between two requesters:

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two data-memory requesters, the arbiter and the memory.
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0_valid;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready;
    logic          req0_rvalid;
    logic [DW-1:0] req0_rdata;

    logic          req1_valid;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready;
    logic          req1_rvalid;
    logic [DW-1:0] req1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core LSU (port 0) and the
// debug/boot loader (port 1). Optional stall counter: define DMEM_ARB_STALL_CNT_EN.
module dmem_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]    stall_cnt
`endif
);
    localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q;
    logic          last_grant_q;
    logic          grant_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [LatW-1:0] lat_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          ready0_q;
    logic          ready1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic any_valid;
    logic pick;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Contention goes to whoever was not served last; a lone requester always wins.
    assign pick = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        grant_q  <= pick;
                        we_q     <= pick ? bus.req1_we    : bus.req0_we;
                        addr_q   <= pick ? bus.req1_addr  : bus.req0_addr;
                        wdata_q  <= pick ? bus.req1_wdata : bus.req0_wdata;
                        mem_en_q <= 1'b1;
                        mem_we_q <= pick ? bus.req1_we    : bus.req0_we;
                        ready0_q <= ~pick;
                        ready1_q <= pick;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    last_grant_q <= grant_q;
                    if (we_q) begin
                        state_q <= StIdle;
                    end else begin
                        lat_q   <= LatW'(RD_LAT - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (lat_q == '0) begin
                        // The port not being answered reads back as zero.
                        rdata0_q  <= grant_q ? '0 : bus.mem_rdata;
                        rdata1_q  <= grant_q ? bus.mem_rdata : '0;
                        rvalid0_q <= ~grant_q;
                        rvalid1_q <= grant_q;
                        state_q   <= StResp;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready  = ready0_q;
    assign bus.req1_ready  = ready1_q;
    assign bus.req0_rvalid = rvalid0_q;
    assign bus.req1_rvalid = rvalid1_q;
    assign bus.req0_rdata  = rdata0_q;
    assign bus.req1_rdata  = rdata1_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;

`ifdef DMEM_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (bus.req0_valid && !ready0_q && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance 0 has RD_LAT=1, instance 1 RD_LAT=3 (same stimulus),
// plus a long-latency instance for stall counter saturation when DMEM_ARB_STALL_CNT_EN is set.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_STALL_CNT_EN
    localparam int NInst = 3;
`else
    localparam int NInst = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_sat = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic        v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;

    logic        rdy0 [NInst], rdy1 [NInst], rv0 [NInst], rv1 [NInst], men [NInst], mwe [NInst];
    logic [31:0] rd0 [NInst], rd1 [NInst], maddr [NInst], mwd [NInst];
`ifdef DMEM_ARB_STALL_CNT_EN
    logic [15:0] stall [NInst];
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NInst; k++) begin : g_inst
        localparam int unsigned Lat = (k == 0) ? 1 : ((k == 1) ? 3 : 1000);
        dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
        logic [31:0] mem [0:63];
        logic [31:0] pipe [0:Lat-1];
        logic        inst_rst;

        assign inst_rst       = (k < 2) ? rst : rst_sat;
        assign bus.req0_valid = (k < 2) ? v0 : 1'b1;
        assign bus.req0_we    = (k < 2) ? we0 : 1'b0;
        assign bus.req0_addr  = (k < 2) ? a0 : 32'h0;
        assign bus.req0_wdata = (k < 2) ? d0 : 32'h0;
        assign bus.req1_valid = (k < 2) ? v1 : 1'b0;
        assign bus.req1_we    = (k < 2) ? we1 : 1'b0;
        assign bus.req1_addr  = (k < 2) ? a1 : 32'h0;
        assign bus.req1_wdata = (k < 2) ? d1 : 32'h0;
        assign bus.mem_rdata  = pipe[Lat-1];

        assign rdy0[k]  = bus.req0_ready;
        assign rdy1[k]  = bus.req1_ready;
        assign rv0[k]   = bus.req0_rvalid;
        assign rv1[k]   = bus.req1_rvalid;
        assign rd0[k]   = bus.req0_rdata;
        assign rd1[k]   = bus.req1_rdata;
        assign men[k]   = bus.mem_en;
        assign mwe[k]   = bus.mem_we;
        assign maddr[k] = bus.mem_addr;
        assign mwd[k]   = bus.mem_wdata;

        // Memory model: data for an access issued in cycle n is presented in cycle n+Lat.
        always @(posedge clk) begin
            if (men[k] && mwe[k]) mem[maddr[k][7:2]] <= mwd[k];
            pipe[0] <= mem[maddr[k][7:2]];
            for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
        end

        dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(Lat)) dut (
            .clk       (clk),
            .rst       (inst_rst),
            .bus       (bus)
`ifdef DMEM_ARB_STALL_CNT_EN
            ,
            .stall_cnt (stall[k])
`endif
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_mem_en", {31'b0, men[0]}, 32'h0);
        chk("rst_ready0", {31'b0, rdy0[0]}, 32'h0);
        chk("rst_rvalid1", {31'b0, rv1[0]}, 32'h0);
        chk("rst_rdata1", rd1[0], 32'h0);
        chk("rst_mem_addr", maddr[0], 32'h0);
        rst = 1'b1;
        rst_sat = 1'b1;
        step();

        // Port 0 write addr 32
        v0 = 1'b1; we0 = 1'b1; a0 = 32'd32; d0 = 32'hDEADBEEF;
        chk("wr_c0_ready0", {31'b0, rdy0[0]}, 32'h0);
        step();
        chk("wr_c1_ready0", {31'b0, rdy0[0]}, 32'h1);
        chk("wr_c1_mem_en", {31'b0, men[0]}, 32'h1);
        chk("wr_c1_mem_we", {31'b0, mwe[0]}, 32'h1);
        chk("wr_c1_mem_addr", maddr[0], 32'd32);
        chk("wr_c1_mem_wdata", mwd[0], 32'hDEADBEEF);
        chk("wr_c1_ready0_lat3", {31'b0, rdy0[1]}, 32'h1);
        step();
        v0 = 1'b0;
        chk("wr_c2_ready0", {31'b0, rdy0[0]}, 32'h0);
        chk("wr_c2_mem_en", {31'b0, men[0]}, 32'h0);
        chk("wr_mem32", g_inst[0].mem[8], 32'hDEADBEEF);
        chk("wr_mem32_lat3", g_inst[1].mem[8], 32'hDEADBEEF);
        step();

        // Port 0 read addr 32: rvalid cycle 3 (RD_LAT=1) and cycle 5 (RD_LAT=3)
        v0 = 1'b1; we0 = 1'b0; a0 = 32'd32;
        step();
        chk("rd_c1_ready0", {31'b0, rdy0[0]}, 32'h1);
        chk("rd_c1_mem_en", {31'b0, men[0]}, 32'h1);
        chk("rd_c1_mem_we", {31'b0, mwe[0]}, 32'h0);
        step();
        v0 = 1'b0;
        chk("rd_c2_rvalid0", {31'b0, rv0[0]}, 32'h0);
        step();
        chk("rd_c3_rvalid0", {31'b0, rv0[0]}, 32'h1);
        chk("rd_c3_rdata0", rd0[0], 32'hDEADBEEF);
        chk("rd_c3_rvalid0_lat3", {31'b0, rv0[1]}, 32'h0);
        chk("rd_c3_rdata1", rd1[0], 32'h0);
        step();
        chk("rd_c4_rvalid0", {31'b0, rv0[0]}, 32'h0);
        chk("rd_c4_rdata0_held", rd0[0], 32'hDEADBEEF);
        chk("rd_c4_rvalid0_lat3", {31'b0, rv0[1]}, 32'h0);
        step();
        chk("rd_c5_rvalid0_lat3", {31'b0, rv0[1]}, 32'h1);
        chk("rd_c5_rdata0_lat3", rd0[1], 32'hDEADBEEF);
        step();
        chk("rd_c6_rvalid0_lat3", {31'b0, rv0[1]}, 32'h0);
        step();

        // Reset while the read is waiting on memory
        v0 = 1'b1; we0 = 1'b0; a0 = 32'd32;
        step();
        step();
        v0 = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_mem_en", {31'b0, men[0]}, 32'h0);
        chk("arst_mem_addr", maddr[0], 32'h0);
        chk("arst_rdata0", rd0[0], 32'h0);
        chk("arst_rdata0_lat3", rd0[1], 32'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("arst_no_rvalid", {30'b0, rv0[0], rv0[1]}, 32'h0);
        end

        // Both ports hold two writes each: grants must alternate 0,1,0,1
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h40; d0 = 32'hA0;
        v1 = 1'b1; we1 = 1'b1; a1 = 32'h44; d1 = 32'hB0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("rr_ready0", {31'b0, rdy0[0]}, {31'b0, (c == 1 || c == 5)});
            chk("rr_ready1", {31'b0, rdy1[0]}, {31'b0, (c == 3 || c == 7)});
            chk("rr_ready1_lat3", {31'b0, rdy1[1]}, {31'b0, (c == 3 || c == 7)});
            if (c == 1) chk("rr_addr_c1", maddr[0], 32'h40);
            if (c == 3) chk("rr_addr_c3", maddr[0], 32'h44);
            if (c == 5) chk("rr_addr_c5", maddr[0], 32'h48);
            if (c == 7) chk("rr_addr_c7", maddr[0], 32'h4C);
            if (c == 2) begin a0 = 32'h48; d0 = 32'hA1; end
            if (c == 4) begin a1 = 32'h4C; d1 = 32'hB1; end
            if (c == 6) v0 = 1'b0;
            if (c == 8) v1 = 1'b0;
        end
        chk("rr_mem48", g_inst[0].mem[18], 32'hA1);
        chk("rr_mem4c", g_inst[0].mem[19], 32'hB1);

        // Loader on port 1 writes then reads mem[0]; port 0 stays quiet
        v1 = 1'b1; we1 = 1'b1; a1 = 32'h0; d1 = 32'h00100093;
        step();
        chk("ld_c1_ready1", {31'b0, rdy1[0]}, 32'h1);
        chk("ld_c1_ready0", {31'b0, rdy0[0]}, 32'h0);
        chk("ld_c1_mem_addr", maddr[0], 32'h0);
        step();
        we1 = 1'b0;
        chk("ld_mem0", g_inst[0].mem[0], 32'h00100093);
        step();
        chk("ld_c3_ready1", {31'b0, rdy1[0]}, 32'h1);
        chk("ld_c3_ready0", {31'b0, rdy0[0]}, 32'h0);
        chk("ld_c3_mem_we", {31'b0, mwe[0]}, 32'h0);
        step();
        v1 = 1'b0;
        step();
        chk("ld_c5_rvalid1", {31'b0, rv1[0]}, 32'h1);
        chk("ld_c5_rdata1", rd1[0], 32'h00100093);
        chk("ld_c5_rvalid0", {31'b0, rv0[0]}, 32'h0);
        chk("ld_c5_rdata0", rd0[0], 32'h0);
        step();
        step();
        chk("ld_c7_rvalid1_lat3", {31'b0, rv1[1]}, 32'h1);
        chk("ld_c7_rdata1_lat3", rd1[1], 32'h00100093);
        step();
        step();

`ifdef DMEM_ARB_STALL_CNT_EN
        // Port 0 blocked for three cycles behind a port 1 read
        chk("st_before", {16'b0, stall[0]}, 32'd4);
        v1 = 1'b1; we1 = 1'b0; a1 = 32'h0;
        step();
        step();
        v1 = 1'b0;
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h50; d0 = 32'h5;
        step();
        step();
        step();
        chk("st_c5_ready0", {31'b0, rdy0[0]}, 32'h1);
        step();
        v0 = 1'b0;
        chk("st_after", {16'b0, stall[0]}, 32'd7);

        // Long-latency instance has had req0 pending since start: counter must pin at max
        while (cyc < 70200) step();
        chk("st_saturate", {16'b0, stall[2]}, 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
